// File: rtl/bridge_utils_pkg.sv
// Shared types for the AXI2APB bridge engine.
// Holds the engine state/direction enums, the burst context and size clamp.
package bridge_utils;

    localparam int MAX_APB_SIZE = 2;
    localparam int CTX_ADDR_W   = 64;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        SETUP,
        ACCESS,
        DONE
    } engine_state_t;

    typedef enum logic {
        READ,
        WRITE
    } dir_t;

    typedef struct packed {
        logic [CTX_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [1:0]            size;
        dir_t                  dir;
    } burst_ctx_t;

    // APB moves at most one 32-bit word, so wider AXI sizes collapse to 4 bytes.
    function automatic logic [1:0] clamp_size(input logic [2:0] s);
        return (s > 3'(MAX_APB_SIZE)) ? 2'(MAX_APB_SIZE) : s[1:0];
    endfunction

endpackage

// File: rtl/bridge_engine_arb.sv
// Two-requester round-robin arbiter (read vs write).
// Ports: req_rd_i/req_wr_i requests, advance_i commits a grant, grant_*_o.
module bridge_rr_arbiter
    import bridge_utils::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_rd_i,
    input  logic req_wr_i,
    input  logic advance_i,
    output logic grant_rd_o,
    output logic grant_wr_o
);

    dir_t last_q;

    // On a tie the side that did not win last time goes first.
    always_comb begin
        grant_rd_o = req_rd_i & (~req_wr_i | (last_q == WRITE));
        grant_wr_o = req_wr_i & ~grant_rd_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= WRITE;
        end else if (advance_i && (grant_rd_o || grant_wr_o)) begin
            last_q <= grant_rd_o ? READ : WRITE;
        end
    end

endmodule

// File: rtl/bridge_engine.sv
// AXI2APB bridge sequencer: arbitrates read/write bursts and walks them
// as APB SETUP/ACCESS beats. Ports: rd_*/wr_* burst handshakes, R/W FIFO
// push/pop, APB master pins. All outputs registered.
module bridge_engine
    import bridge_utils::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    input  logic [7:0]              rd_len,
    input  logic [2:0]              rd_size,
    output logic                    rd_grant,
    output logic                    rd_done,
    input  logic                    rdata_ready,
    output logic                    rdata_valid,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rdata_last,
    output logic                    rdata_err,
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [7:0]              wr_len,
    input  logic [2:0]              wr_size,
    output logic                    wr_grant,
    output logic                    wr_done,
    input  logic                    wdata_valid,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wdata_read,
    output logic                    wr_err,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TCW-1:0] TLIM =
        TCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CTX_ADDR_W-1:0] AMASK =
        (ADDR_WIDTH >= CTX_ADDR_W) ? {CTX_ADDR_W{1'b1}}
                                   : ((CTX_ADDR_W'(1) << ADDR_WIDTH) - CTX_ADDR_W'(1));

    engine_state_t   state_q;
    burst_ctx_t      ctx_q;
    logic [7:0]      beat_q;
    logic            err_q;
    logic [TCW-1:0]  tcnt_q;

    logic            gnt_rd;
    logic            gnt_wr;
    logic            is_wr;
    logic            beat_ok;
    logic            last_beat;
    logic            timeout;
    logic            beat_end;
    logic            beat_err;
    logic [CTX_ADDR_W-1:0] addr_nxt;

    bridge_rr_arbiter u_arb (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_rd_i   (rd_req),
        .req_wr_i   (wr_req),
        .advance_i  (state_q == IDLE),
        .grant_rd_o (gnt_rd),
        .grant_wr_o (gnt_wr)
    );

    always_comb begin
        is_wr     = (ctx_q.dir == WRITE);
        beat_ok   = is_wr ? wdata_valid : rdata_ready;
        last_beat = (beat_q == ctx_q.len);
        // A timeout only counts when the slave has not answered this cycle.
        timeout   = (TIMEOUT_CYCLES != 0) && !pready && (tcnt_q == TLIM);
        beat_end  = pready | timeout;
        beat_err  = (pready & pslverr) | timeout;
        // Masking keeps the INCR walk modulo the APB address width.
        addr_nxt  = (ctx_q.addr + (CTX_ADDR_W'(1) << ctx_q.size)) & AMASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ctx_q       <= '0;
            beat_q      <= '0;
            err_q       <= 1'b0;
            tcnt_q      <= '0;
            rd_grant    <= 1'b0;
            rd_done     <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            rdata_last  <= 1'b0;
            rdata_err   <= 1'b0;
            wr_grant    <= 1'b0;
            wr_done     <= 1'b0;
            wdata_read  <= 1'b0;
            wr_err      <= 1'b0;
            paddr       <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            pstrb       <= '0;
        end else begin
            rd_grant    <= 1'b0;
            rd_done     <= 1'b0;
            rdata_valid <= 1'b0;
            wr_grant    <= 1'b0;
            wr_done     <= 1'b0;
            wdata_read  <= 1'b0;
            wr_err      <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (gnt_rd || gnt_wr) begin
                        ctx_q.dir  <= gnt_rd ? READ : WRITE;
                        ctx_q.addr <= gnt_rd ? CTX_ADDR_W'(rd_addr)
                                             : CTX_ADDR_W'(wr_addr);
                        ctx_q.len  <= gnt_rd ? rd_len : wr_len;
                        ctx_q.size <= gnt_rd ? clamp_size(rd_size)
                                             : clamp_size(wr_size);
                        beat_q     <= '0;
                        err_q      <= 1'b0;
                        rd_grant   <= gnt_rd;
                        wr_grant   <= gnt_wr;
                        state_q    <= PREP;
                    end
                end
                PREP: begin
                    if (beat_ok) begin
                        if (is_wr) begin
                            pwdata     <= wdata;
                            pstrb      <= wstrb;
                            wdata_read <= 1'b1;
                        end else begin
                            pstrb      <= '0;
                        end
                        paddr   <= ctx_q.addr[ADDR_WIDTH-1:0];
                        pwrite  <= is_wr;
                        psel    <= 1'b1;
                        penable <= 1'b0;
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    tcnt_q  <= '0;
                    state_q <= ACCESS;
                end
                ACCESS: begin
                    if (beat_end) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (is_wr) begin
                            err_q <= err_q | beat_err;
                        end else begin
                            rdata_valid <= 1'b1;
                            rdata       <= prdata;
                            rdata_err   <= beat_err;
                            rdata_last  <= last_beat;
                        end
                        if (last_beat) begin
                            state_q <= DONE;
                        end else begin
                            beat_q     <= beat_q + 8'd1;
                            ctx_q.addr <= addr_nxt;
                            state_q    <= PREP;
                        end
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                DONE: begin
                    rd_done <= ~is_wr;
                    wr_done <= is_wr;
                    wr_err  <= is_wr & err_q;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
